// File: rtl/bcd_scan_display.sv
// bcd_scan_display
// Time-multiplexed 7-segment driver for a chain of BCD counter digits.
// A prescaler holds each digit for PRESCALE clocks. A two-state scan FSM
// steps through the digits. A frame snapshot of digits/dp_in is reloaded
// only on IDLE->SCAN or when the frame wraps, so the display never tears
// while the counters change mid-frame.
//
// Optional build macro: BCD_SCAN_LZB_EN enables leading-zero blanking,
// which is evaluated on the snapshot.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   en         scan enable; 0 blanks the display
//   digits     packed BCD, digit k at [4k+3:4k], digit 0 least significant
//   dp_in      per-digit decimal point, active-high
//   seg        segments {g,f,e,d,c,b,a}, active-high, registered
//   dp         decimal point of the active digit, registered
//   an         one-hot digit select, active-high, registered
//   frame_done one-cycle pulse when the last digit's hold period ends
module bcd_scan_display #(
    parameter int unsigned NUM_DIG  = 4,
    parameter int unsigned PRESCALE = 1000,
    parameter int unsigned CW       = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [4*NUM_DIG-1:0]   digits,
    input  logic [NUM_DIG-1:0]     dp_in,
    output logic [6:0]             seg,
    output logic                   dp,
    output logic [NUM_DIG-1:0]     an,
    output logic                   frame_done
);

    localparam int unsigned IW = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t               r_state, w_state_nxt;
    logic [CW-1:0]        r_cnt, w_cnt_nxt;
    logic [IW-1:0]        r_idx, w_idx_nxt;
    logic [4*NUM_DIG-1:0] r_snap;
    logic [NUM_DIG-1:0]   r_snap_dp;
    logic                 w_load;
    logic                 w_wrap;
    logic [3:0]           w_dig;
    logic                 w_dp_sel;
    logic                 w_blank_sel;
    logic [6:0]           w_seg_dec;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    bcd_to_seg = 7'h3F;
            4'd1:    bcd_to_seg = 7'h06;
            4'd2:    bcd_to_seg = 7'h5B;
            4'd3:    bcd_to_seg = 7'h4F;
            4'd4:    bcd_to_seg = 7'h66;
            4'd5:    bcd_to_seg = 7'h6D;
            4'd6:    bcd_to_seg = 7'h7D;
            4'd7:    bcd_to_seg = 7'h07;
            4'd8:    bcd_to_seg = 7'h7F;
            4'd9:    bcd_to_seg = 7'h6F;
            default: bcd_to_seg = 7'h40;  // non-BCD code shows "-"
        endcase
    endfunction

    // Next-state logic for the scan FSM, prescaler and digit index
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_load      = 1'b0;
        w_wrap      = 1'b0;
        case (r_state)
            IDLE: begin
                if (en) begin
                    w_state_nxt = SCAN;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_load      = 1'b1;
                end
            end
            SCAN: begin
                if (!en) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end else if (r_cnt == CW'(PRESCALE - 1)) begin
                    w_cnt_nxt = '0;
                    if (r_idx == IW'(NUM_DIG - 1)) begin
                        w_idx_nxt = '0;
                        w_wrap    = 1'b1;
                        w_load    = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef BCD_SCAN_LZB_EN
    // w_blank[k] is set when snapshot digit k and every digit above it is 0.
    // Digit 0 is never blanked; invalid codes count as non-zero.
    logic [NUM_DIG-1:0] w_blank;
    always_comb begin
        logic hi_zero;
        w_blank = '0;
        hi_zero = 1'b1;
        for (int unsigned j = 0; j < NUM_DIG - 1; j++) begin
            hi_zero = hi_zero & (r_snap[4*(NUM_DIG-1-j) +: 4] == 4'd0);
            w_blank[NUM_DIG-1-j] = hi_zero;
        end
    end
`endif

    // Select the active digit from the snapshot
    always_comb begin
        w_dig       = '0;
        w_dp_sel    = 1'b0;
        w_blank_sel = 1'b0;
        for (int unsigned k = 0; k < NUM_DIG; k++) begin
            if (r_idx == IW'(k)) begin
                w_dig    = r_snap[4*k +: 4];
                w_dp_sel = r_snap_dp[k];
`ifdef BCD_SCAN_LZB_EN
                w_blank_sel = w_blank[k];
`endif
            end
        end
        w_seg_dec = w_blank_sel ? 7'h00 : bcd_to_seg(w_dig);
    end

    // Output registers follow the current (pre-edge) state, one cycle behind
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_snap     <= '0;
            r_snap_dp  <= '0;
            seg        <= '0;
            dp         <= 1'b0;
            an         <= '0;
            frame_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            frame_done <= w_wrap;
            if (w_load) begin
                r_snap    <= digits;
                r_snap_dp <= dp_in;
            end
            if (r_state == SCAN) begin
                an  <= NUM_DIG'(1) << r_idx;
                seg <= w_seg_dec;
                dp  <= w_dp_sel;
            end else begin
                an  <= '0;
                seg <= '0;
                dp  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed self-checking bench for bcd_scan_display (NUM_DIG=4, PRESCALE=4).
module tb_bcd_scan_display;

`ifdef BCD_SCAN_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    bcd_scan_display #(
        .NUM_DIG (4),
        .PRESCALE(4),
        .CW      (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .digits    (digits),
        .dp_in     (dp_in),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Check one digit's display for n cycles; frame_done is expected on the
    // final cycle of a full hold of the last digit.
    task automatic hold(input logic [3:0] an_e, input logic [6:0] seg_e,
                        input logic dp_e, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("an", 32'(an), 32'(an_e));
            chk("seg", 32'(seg), 32'(seg_e));
            chk("dp", 32'(dp), 32'(dp_e));
            chk("frame_done", 32'(frame_done), 32'(an_e == 4'b1000 && n == 4 && i == n - 1));
        end
    endtask

    task automatic chk_blank(input string tag);
        chk(tag, {25'd0, seg, dp, an, frame_done}, 32'd0);
    endtask

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        digits = 16'h0000;
        dp_in  = 4'b0000;
        tick();
        tick();
        chk_blank("reset");

        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_blank("idle");
        end

        // Basic scan of 0x1234 with dp on digit 2
        digits = 16'h1234;
        dp_in  = 4'b0100;
        en     = 1'b1;
        tick();
        chk("first_an", 32'(an), 32'd0);
        hold(4'b0001, 7'h66, 1'b0, 4);
        hold(4'b0010, 7'h4F, 1'b0, 4);
        hold(4'b0100, 7'h5B, 1'b1, 4);
        hold(4'b1000, 7'h06, 1'b0, 4);

        // Snapshot: change inputs while digit 1 is shown
        hold(4'b0001, 7'h66, 1'b0, 4);
        hold(4'b0010, 7'h4F, 1'b0, 1);
        digits = 16'h9876;
        hold(4'b0010, 7'h4F, 1'b0, 3);
        hold(4'b0100, 7'h5B, 1'b1, 4);
        hold(4'b1000, 7'h06, 1'b0, 4);
        hold(4'b0001, 7'h7D, 1'b0, 4);
        hold(4'b0010, 7'h07, 1'b0, 4);
        hold(4'b0100, 7'h7F, 1'b1, 4);
        digits = 16'hF90A;
        hold(4'b1000, 7'h6F, 1'b0, 4);

        // Invalid codes and a zero in the middle (never blanked: 9 above it)
        hold(4'b0001, 7'h40, 1'b0, 4);
        hold(4'b0010, 7'h3F, 1'b0, 4);
        hold(4'b0100, 7'h6F, 1'b1, 4);
        hold(4'b1000, 7'h40, 1'b0, 4);

        // Disable during digit 2
        hold(4'b0001, 7'h40, 1'b0, 4);
        hold(4'b0010, 7'h3F, 1'b0, 4);
        hold(4'b0100, 7'h6F, 1'b1, 2);
        en = 1'b0;
        tick();
        chk("dis_an", 32'(an), 32'b0100);
        tick();
        chk_blank("dis_blank");
        tick();
        chk_blank("dis_idle");

        // Re-enable restarts at digit 0 with a fresh snapshot
        digits = 16'h5678;
        dp_in  = 4'b0001;
        en     = 1'b1;
        tick();
        chk("reen_an", 32'(an), 32'd0);
        hold(4'b0001, 7'h7F, 1'b1, 4);
        hold(4'b0010, 7'h07, 1'b0, 2);

        // Reset mid-scan with en high
        rst = 1'b1;
        tick();
        chk_blank("rst_mid");
        digits = 16'h0070;
        dp_in  = 4'b0000;
        tick();
        chk_blank("rst_hold");
        rst = 1'b0;

        // Leading zeros (blanked only with the feature built in)
        tick();
        chk("lz_an", 32'(an), 32'd0);
        hold(4'b0001, 7'h3F, 1'b0, 4);
        hold(4'b0010, 7'h07, 1'b0, 4);
        hold(4'b0100, LZB ? 7'h00 : 7'h3F, 1'b0, 4);
        digits = 16'h0000;
        hold(4'b1000, LZB ? 7'h00 : 7'h3F, 1'b0, 4);
        hold(4'b0001, 7'h3F, 1'b0, 4);
        hold(4'b0010, LZB ? 7'h00 : 7'h3F, 1'b0, 4);
        hold(4'b0100, LZB ? 7'h00 : 7'h3F, 1'b0, 4);
        hold(4'b1000, LZB ? 7'h00 : 7'h3F, 1'b0, 4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
